// File: rtl/mem_sys_initiator.sv
// ---------------------------------------------------------------------------
// mem_sys_initiator
//
// System-side initiator for the cmd_valid_sys / ready_sys memory command
// handshake. Client requests are queued in a small command FIFO and issued
// one at a time. Write data is driven toward the shared data bus, and read
// data is captured from it. Each completed or timed-out command produces a
// one-cycle response pulse.
//
// Handshake semantics:
//   client side : a request is taken on any rising edge where
//                 req_valid && req_ready. req_ready is simply "FIFO not full".
//                 It does not look at a same-cycle pop.
//   system side : cmd_valid_sys is raised with we/addr/data already stable.
//                 It drops one cycle after ready_sys is first sampled high, or
//                 after TIMEOUT low cycles. No new command is raised until
//                 ready_sys has been seen low again (RELEASE).
//   response    : rsp_valid is a single-cycle pulse with no backpressure.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   req_*             client request (valid/ready, we, addr, wdata)
//   rsp_*             completion pulse with echoed we/addr, err and rdata
//   cmd_valid_sys, we_sys, addr_sys       command toward the controller
//   data_sys_out, data_sys_oe, data_sys_in   shared data bus (tristated above)
//   ready_sys         controller acknowledge
//   busy, level       status (decoded from registers)
// ---------------------------------------------------------------------------
module mem_sys_initiator #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [7:0]               req_addr,
  input  logic [7:0]               req_wdata,
  output logic                     rsp_valid,
  output logic                     rsp_we,
  output logic                     rsp_err,
  output logic [7:0]               rsp_addr,
  output logic [7:0]               rsp_rdata,
  output logic                     cmd_valid_sys,
  output logic                     we_sys,
  output logic [7:0]               addr_sys,
  output logic [7:0]               data_sys_out,
  output logic                     data_sys_oe,
  input  logic [7:0]               data_sys_in,
  input  logic                     ready_sys,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CMD     = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // FIFO entry layout: {we, addr[7:0], wdata[7:0]}
  logic [16:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;

  logic          r_cmd_valid;
  logic          r_we;
  logic [7:0]    r_addr;
  logic [7:0]    r_wdata;
  logic          r_oe;
  logic [7:0]    r_wait;

  logic          r_rsp_valid;
  logic          r_rsp_we;
  logic          r_rsp_err;
  logic [7:0]    r_rsp_addr;
  logic [7:0]    r_rsp_rdata;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_issue;
  logic          w_ack;
  logic          w_tmo;
  logic          w_wait_inc;
  logic          w_wait_hit;
  logic [16:0]   w_head;

  assign w_full  = (r_level == LW'(DEPTH));
  assign w_empty = (r_level == '0);
  assign w_push  = req_valid && !w_full;
  assign w_head  = r_mem[r_rptr];

  // r_wait counts completed low-ready CMD cycles, so the TIMEOUT-th low cycle
  // is the one where r_wait == TIMEOUT-1.
  assign w_wait_hit = (TIMEOUT != 0) && (r_wait == 8'(TIMEOUT - 1));

  // Next-state and transition events
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_ack       = 1'b0;
    w_tmo       = 1'b0;
    w_wait_inc  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_issue     = 1'b1;
          w_state_nxt = ST_CMD;
        end
      end
      ST_CMD: begin
        if (ready_sys) begin
          w_ack       = 1'b1;
          w_state_nxt = ST_RELEASE;
        end else if (w_wait_hit) begin
          w_tmo       = 1'b1;
          w_state_nxt = ST_RELEASE;
        end else begin
          w_wait_inc  = 1'b1;
        end
      end
      ST_RELEASE: begin
        // Wait for the controller to drop ready before issuing again.
        if (!ready_sys) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_level     <= '0;
      r_cmd_valid <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= 8'h00;
      r_wdata     <= 8'h00;
      r_oe        <= 1'b0;
      r_wait      <= 8'h00;
      r_rsp_valid <= 1'b0;
      r_rsp_we    <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_addr  <= 8'h00;
      r_rsp_rdata <= 8'h00;
    end else begin
      r_state     <= w_state_nxt;
      r_rsp_valid <= 1'b0;

      if (w_push) begin
        r_mem[r_wptr] <= {req_we, req_addr, req_wdata};
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_issue) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_issue})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase

      if (w_issue) begin
        r_we        <= w_head[16];
        r_addr      <= w_head[15:8];
        r_wdata     <= w_head[7:0];
        r_cmd_valid <= 1'b1;
        r_oe        <= w_head[16];
        r_wait      <= 8'h00;
      end

      if (w_wait_inc) begin
        r_wait <= r_wait + 8'd1;
      end

      if (w_ack || w_tmo) begin
        r_cmd_valid <= 1'b0;
        r_oe        <= 1'b0;
        r_rsp_valid <= 1'b1;
        r_rsp_we    <= r_we;
        r_rsp_addr  <= r_addr;
        r_rsp_err   <= w_tmo;
        r_rsp_rdata <= (w_ack && !r_we) ? data_sys_in : 8'h00;
      end
    end
  end

  assign req_ready     = !w_full;
  assign busy          = (r_state != ST_IDLE) || !w_empty;
  assign level         = r_level;

  assign cmd_valid_sys = r_cmd_valid;
  assign we_sys        = r_we;
  assign addr_sys      = r_addr;
  assign data_sys_out  = r_wdata;
  assign data_sys_oe   = r_oe;

  assign rsp_valid     = r_rsp_valid;
  assign rsp_we        = r_rsp_we;
  assign rsp_err       = r_rsp_err;
  assign rsp_addr      = r_rsp_addr;
  assign rsp_rdata     = r_rsp_rdata;

endmodule

// File: tb/tb_mem_sys_initiator.sv
// ---------------------------------------------------------------------------
// tb_mem_sys_initiator
//
// Directed bench for mem_sys_initiator (DEPTH=4, TIMEOUT=15). The step task
// advances one clock and then applies the reference responder. When enabled,
// ready_sys after edge n is high only if cmd_valid_sys was high after both
// edges n-1 and n-2. With the responder disabled, ready_sys is driven by hand.
// ---------------------------------------------------------------------------
module tb_mem_sys_initiator;

  logic       clk;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_we;
  logic       rsp_err;
  logic [7:0] rsp_addr;
  logic [7:0] rsp_rdata;
  logic       cmd_valid_sys;
  logic       we_sys;
  logic [7:0] addr_sys;
  logic [7:0] data_sys_out;
  logic       data_sys_oe;
  logic [7:0] data_sys_in;
  logic       ready_sys;
  logic       busy;
  logic [2:0] level;

  int n_pass;
  int n_total;

  bit resp_en;
  bit resp_r1;

  logic [7:0] exp_q[$];

  mem_sys_initiator #(.DEPTH(4), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_we(rsp_we), .rsp_err(rsp_err),
    .rsp_addr(rsp_addr), .rsp_rdata(rsp_rdata),
    .cmd_valid_sys(cmd_valid_sys), .we_sys(we_sys), .addr_sys(addr_sys),
    .data_sys_out(data_sys_out), .data_sys_oe(data_sys_oe),
    .data_sys_in(data_sys_in), .ready_sys(ready_sys),
    .busy(busy), .level(level)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // driver tasks
  task automatic step();
    logic prev;
    prev = cmd_valid_sys;
    @(posedge clk);
    #1;
    if (resp_en) ready_sys = resp_r1 & prev;
    resp_r1 = prev;
  endtask

  task automatic push(input logic we, input logic [7:0] addr, input logic [7:0] data);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = data;
    step();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && busy; i++) step();
    for (int i = 0; i < 4; i++) step();
    n_total++;
    if (busy !== 1'b0) $display("FAIL drain: busy=%b required 0", busy);
    else n_pass++;
  endtask

  // tests
  task automatic test_reset();
    reset = 1'b1; resp_en = 1'b0; ready_sys = 1'b0; resp_r1 = 1'b0;
    step(); step();
    n_total++;
    if ({cmd_valid_sys, we_sys, data_sys_oe, rsp_valid, rsp_we, rsp_err} !== 6'b0)
      $display("FAIL reset_flags: got %b required 000000",
               {cmd_valid_sys, we_sys, data_sys_oe, rsp_valid, rsp_we, rsp_err});
    else n_pass++;
    n_total++;
    if ({addr_sys, data_sys_out, rsp_addr, rsp_rdata} !== 32'h0)
      $display("FAIL reset_data: got %h required 0", {addr_sys, data_sys_out, rsp_addr, rsp_rdata});
    else n_pass++;
    n_total++;
    if ({level, req_ready, busy} !== {3'd0, 1'b1, 1'b0})
      $display("FAIL reset_status: level=%0d req_ready=%b busy=%b required 0/1/0", level, req_ready, busy);
    else n_pass++;
    reset = 1'b0;
    step();
  endtask

  task automatic test_write();
    resp_en = 1'b1;
    push(1'b1, 8'h3C, 8'hA5);                       // E0
    n_total++;
    if ({level, cmd_valid_sys} !== {3'd1, 1'b0})
      $display("FAIL wr_e0: level=%0d cmd_valid=%b required 1/0", level, cmd_valid_sys);
    else n_pass++;
    step();                                         // E1
    n_total++;
    if ({cmd_valid_sys, data_sys_oe, we_sys, addr_sys, data_sys_out} !== {1'b1, 1'b1, 1'b1, 8'h3C, 8'hA5})
      $display("FAIL wr_issue: v=%b oe=%b we=%b addr=%h data=%h required 1/1/1/3c/a5",
               cmd_valid_sys, data_sys_oe, we_sys, addr_sys, data_sys_out);
    else n_pass++;
    step(); step();                                 // E3
    n_total++;
    if ({cmd_valid_sys, data_sys_oe, data_sys_out, rsp_valid} !== {1'b1, 1'b1, 8'hA5, 1'b0})
      $display("FAIL wr_hold: v=%b oe=%b data=%h rsp_valid=%b required 1/1/a5/0",
               cmd_valid_sys, data_sys_oe, data_sys_out, rsp_valid);
    else n_pass++;
    step();                                         // E4
    n_total++;
    if ({rsp_valid, rsp_we, rsp_err, rsp_addr, rsp_rdata, cmd_valid_sys, data_sys_oe}
        !== {1'b1, 1'b1, 1'b0, 8'h3C, 8'h00, 1'b0, 1'b0})
      $display("FAIL wr_rsp: valid=%b we=%b err=%b addr=%h rdata=%h v=%b oe=%b required 1/1/0/3c/00/0/0",
               rsp_valid, rsp_we, rsp_err, rsp_addr, rsp_rdata, cmd_valid_sys, data_sys_oe);
    else n_pass++;
    step();                                         // E5
    n_total++;
    if ({rsp_valid, busy} !== 2'b01)
      $display("FAIL wr_e5: rsp_valid=%b busy=%b required 0/1", rsp_valid, busy);
    else n_pass++;
    step();                                         // E6
    n_total++;
    if (busy !== 1'b0) $display("FAIL wr_idle_e6: busy=%b required 0", busy);
    else n_pass++;
  endtask

  task automatic test_read();
    int oe_bad, rsp_cnt;
    logic [7:0] c_rdata, c_addr;
    logic c_err, c_we;
    oe_bad = 0; rsp_cnt = 0; c_rdata = 8'h00; c_addr = 8'h00; c_err = 1'b1; c_we = 1'b1;
    resp_en = 1'b1;
    data_sys_in = 8'h5A;
    push(1'b0, 8'h10, 8'hEE);
    for (int i = 0; i < 12; i++) begin
      step();
      if (data_sys_oe !== 1'b0) oe_bad++;
      if (rsp_valid === 1'b1) begin
        rsp_cnt++;
        c_rdata = rsp_rdata; c_addr = rsp_addr; c_err = rsp_err; c_we = rsp_we;
      end
    end
    n_total++;
    if (oe_bad != 0) $display("FAIL rd_oe: oe high in %0d cycles required 0", oe_bad);
    else n_pass++;
    n_total++;
    if (rsp_cnt != 1) $display("FAIL rd_pulse: rsp_valid cycles=%0d required 1", rsp_cnt);
    else n_pass++;
    n_total++;
    if ({c_rdata, c_addr, c_err, c_we} !== {8'h5A, 8'h10, 1'b0, 1'b0})
      $display("FAIL rd_rsp: rdata=%h addr=%h err=%b we=%b required 5a/10/0/0", c_rdata, c_addr, c_err, c_we);
    else n_pass++;
    drain();
  endtask

  task automatic test_back_to_back();
    int e_rsp1, e_iss2;
    e_rsp1 = -1; e_iss2 = -1;
    resp_en = 1'b1;
    push(1'b1, 8'h60, 8'h11);                       // E0
    push(1'b1, 8'h61, 8'h22);                       // E1
    for (int e = 2; e < 20; e++) begin
      step();
      if (rsp_valid === 1'b1 && e_rsp1 < 0) e_rsp1 = e;
      if (cmd_valid_sys === 1'b1 && addr_sys === 8'h61 && e_iss2 < 0) e_iss2 = e;
    end
    n_total++;
    if (e_rsp1 != 4) $display("FAIL b2b_rsp1: first rsp at E%0d required E4", e_rsp1);
    else n_pass++;
    n_total++;
    if (e_iss2 != 7) $display("FAIL b2b_issue2: second issue at E%0d required E7", e_iss2);
    else n_pass++;
    drain();
  endtask

  task automatic test_full();
    int extra, bad_order, errs;
    extra = 0; bad_order = 0; errs = 0;
    resp_en = 1'b0; ready_sys = 1'b0;
    push(1'b1, 8'h20, 8'h00);                       // E0
    step();                                         // E1: issued, stalls
    for (int i = 1; i <= 4; i++) push(1'b1, 8'(8'h20 + i), 8'(i));
    n_total++;
    if ({level, req_ready} !== {3'd4, 1'b0})
      $display("FAIL full_after4: level=%0d req_ready=%b required 4/0", level, req_ready);
    else n_pass++;
    push(1'b1, 8'h25, 8'h55);                       // refused
    n_total++;
    if (level !== 3'd4) $display("FAIL full_refuse: level=%0d required 4", level);
    else n_pass++;
    exp_q = {};
    for (int i = 0; i < 5; i++) exp_q.push_back(8'(8'h20 + i));
    resp_en = 1'b1;
    for (int i = 0; i < 80; i++) begin
      step();
      if (rsp_valid === 1'b1) begin
        if (rsp_err !== 1'b0) errs++;
        if (exp_q.size() == 0) extra++;
        else begin
          n_total++;
          if (rsp_addr !== exp_q[0])
            $display("FAIL full_order: rsp_addr=%h required %h", rsp_addr, exp_q[0]);
          else n_pass++;
          void'(exp_q.pop_front());
        end
      end
    end
    n_total++;
    if (exp_q.size() != 0 || extra != 0 || errs != 0)
      $display("FAIL full_complete: missing=%0d extra=%0d errs=%0d required 0/0/0", exp_q.size(), extra, errs);
    else n_pass++;
    drain();
  endtask

  task automatic test_timeout();
    int cnt;
    bit got;
    cnt = 0; got = 1'b0;
    resp_en = 1'b0; ready_sys = 1'b0;
    data_sys_in = 8'hFF;
    push(1'b0, 8'h40, 8'h00);                       // E0
    push(1'b1, 8'h41, 8'h77);                       // E1: issue 0x40, queue 0x41
    if (cmd_valid_sys === 1'b1) cnt = 1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (rsp_valid === 1'b1) begin got = 1'b1; break; end
      if (cmd_valid_sys === 1'b1) cnt++;
    end
    n_total++;
    if (!got || cnt != 15) $display("FAIL tmo_len: got_rsp=%b cmd_valid cycles=%0d required 1/15", got, cnt);
    else n_pass++;
    n_total++;
    if ({rsp_err, rsp_rdata, rsp_addr, rsp_we, cmd_valid_sys} !== {1'b1, 8'h00, 8'h40, 1'b0, 1'b0})
      $display("FAIL tmo_rsp: err=%b rdata=%h addr=%h we=%b v=%b required 1/00/40/0/0",
               rsp_err, rsp_rdata, rsp_addr, rsp_we, cmd_valid_sys);
    else n_pass++;
    step();
    n_total++;
    if (cmd_valid_sys !== 1'b0) $display("FAIL tmo_release: cmd_valid=%b required 0", cmd_valid_sys);
    else n_pass++;
    step();
    n_total++;
    if ({cmd_valid_sys, addr_sys, we_sys, data_sys_oe, data_sys_out} !== {1'b1, 8'h41, 1'b1, 1'b1, 8'h77})
      $display("FAIL tmo_next: v=%b addr=%h we=%b oe=%b data=%h required 1/41/1/1/77",
               cmd_valid_sys, addr_sys, we_sys, data_sys_oe, data_sys_out);
    else n_pass++;
    resp_en = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (rsp_valid === 1'b1) got = 1'b1;
    end
    n_total++;
    if ({got, rsp_err, rsp_addr} !== {1'b1, 1'b0, 8'h41})
      $display("FAIL tmo_next_rsp: got=%b err=%b addr=%h required 1/0/41", got, rsp_err, rsp_addr);
    else n_pass++;
    drain();
  endtask

  task automatic test_release();
    int bad;
    bad = 0;
    resp_en = 1'b0; ready_sys = 1'b0;
    push(1'b1, 8'h50, 8'h01);                       // E0
    push(1'b1, 8'h51, 8'h02);                       // E1: issue 0x50
    ready_sys = 1'b1;
    step();                                         // ack sampled
    n_total++;
    if ({rsp_valid, cmd_valid_sys, rsp_addr} !== {1'b1, 1'b0, 8'h50})
      $display("FAIL rel_ack: rsp_valid=%b v=%b addr=%h required 1/0/50", rsp_valid, cmd_valid_sys, rsp_addr);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      step();
      if (cmd_valid_sys !== 1'b0) bad++;
    end
    n_total++;
    if (bad != 0) $display("FAIL rel_hold: cmd_valid high in %0d cycles required 0", bad);
    else n_pass++;
    ready_sys = 1'b0;
    step();
    n_total++;
    if (cmd_valid_sys !== 1'b0) $display("FAIL rel_exit: cmd_valid=%b required 0", cmd_valid_sys);
    else n_pass++;
    step();
    n_total++;
    if ({cmd_valid_sys, addr_sys} !== {1'b1, 8'h51})
      $display("FAIL rel_next: v=%b addr=%h required 1/51", cmd_valid_sys, addr_sys);
    else n_pass++;
    ready_sys = 1'b1;
    step();
    ready_sys = 1'b0;
    drain();
  endtask

  task automatic test_reset_mid();
    int rsp_cnt, cmd_cnt;
    rsp_cnt = 0; cmd_cnt = 0;
    resp_en = 1'b0; ready_sys = 1'b0;
    for (int i = 0; i < 4; i++) push(1'b1, 8'(8'h70 + i), 8'(i));
    n_total++;
    if ({level, cmd_valid_sys} !== {3'd3, 1'b1})
      $display("FAIL mid_pre: level=%0d v=%b required 3/1", level, cmd_valid_sys);
    else n_pass++;
    reset = 1'b1;
    step();
    n_total++;
    if ({cmd_valid_sys, level, busy, req_ready} !== {1'b0, 3'd0, 1'b0, 1'b1})
      $display("FAIL mid_reset: v=%b level=%0d busy=%b req_ready=%b required 0/0/0/1",
               cmd_valid_sys, level, busy, req_ready);
    else n_pass++;
    reset = 1'b0;
    resp_r1 = 1'b0;
    resp_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (rsp_valid === 1'b1) rsp_cnt++;
      if (cmd_valid_sys === 1'b1) cmd_cnt++;
    end
    n_total++;
    if (rsp_cnt != 0 || cmd_cnt != 0 || busy !== 1'b0)
      $display("FAIL mid_after: rsp=%0d cmd=%0d busy=%b required 0/0/0", rsp_cnt, cmd_cnt, busy);
    else n_pass++;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
    data_sys_in = 8'h00; ready_sys = 1'b0; resp_en = 1'b0; resp_r1 = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_full();
    test_timeout();
    test_release();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
